// File: rtl/wb_forward_pipe.sv
// Writeback pipeline with register-file forwarding.
// STAGES slots carry {valid, addr, data}; slot 0 is youngest and slot STAGES-1
// drives the register-file write port. Lookups return the youngest valid match.
module wb_forward_pipe #(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 5,
   parameter int STAGES = 2,
   parameter int FWD_EN = 1
) (
   input  logic              wf_clk,
   input  logic              wf_rst,
   input  logic              wf_i_valid,
   input  logic              wf_i_we_reg,
   input  logic [AWIDTH-1:0] wf_i_addr_rd,
   input  logic [DWIDTH-1:0] wf_i_data_rd,
   input  logic              wf_i_stall,
   input  logic              wf_i_flush,
   input  logic [AWIDTH-1:0] wf_i_addr_rs1,
   input  logic [AWIDTH-1:0] wf_i_addr_rs2,
   output logic              wf_o_fwd_rs1_hit,
   output logic              wf_o_fwd_rs2_hit,
   output logic [DWIDTH-1:0] wf_o_fwd_rs1_data,
   output logic [DWIDTH-1:0] wf_o_fwd_rs2_data,
   output logic              wf_o_we,
   output logic [AWIDTH-1:0] wf_o_addr_rd,
   output logic [DWIDTH-1:0] wf_o_data_rd,
   output logic              wf_o_busy,
   output logic [31:0]       wf_o_retire_cnt
);

   logic              slot_valid [STAGES];
   logic [AWIDTH-1:0] slot_addr  [STAGES];
   logic [DWIDTH-1:0] slot_data  [STAGES];
   logic [31:0]       retire_cnt;
   logic              in_valid;

   // Writes to x0 are never tracked, so they can neither commit nor forward.
   assign in_valid = wf_i_valid & wf_i_we_reg & (wf_i_addr_rd != '0);

   // Slot shift register: flush clears all valids (the oldest commits this
   // cycle through the write port), stall holds, otherwise shift by one.
   always_ff @(posedge wf_clk or negedge wf_rst) begin
      if (!wf_rst) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            slot_valid[k] <= 1'b0;
            slot_addr[k]  <= '0;
            slot_data[k]  <= '0;
         end
      end else if (wf_i_flush) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            slot_valid[k] <= 1'b0;
         end
      end else if (!wf_i_stall) begin
         slot_valid[0] <= in_valid;
         slot_addr[0]  <= wf_i_addr_rd;
         slot_data[0]  <= wf_i_data_rd;
         for (int unsigned k = 1; k < STAGES; k++) begin
            slot_valid[k] <= slot_valid[k-1];
            slot_addr[k]  <= slot_addr[k-1];
            slot_data[k]  <= slot_data[k-1];
         end
      end
   end

   // Flush overrides stall, so the oldest entry still commits on a flush.
   assign wf_o_we         = slot_valid[STAGES-1] & (~wf_i_stall | wf_i_flush);
   assign wf_o_addr_rd    = slot_addr[STAGES-1];
   assign wf_o_data_rd    = slot_data[STAGES-1];
   assign wf_o_retire_cnt = retire_cnt;

   // Busy whenever any slot holds a valid entry.
   always_comb begin
      wf_o_busy = 1'b0;
      for (int unsigned k = 0; k < STAGES; k++) begin
         wf_o_busy = wf_o_busy | slot_valid[k];
      end
   end

   // Forward lookup: scan oldest to youngest so the youngest match wins.
   always_comb begin
      wf_o_fwd_rs1_hit  = 1'b0;
      wf_o_fwd_rs2_hit  = 1'b0;
      wf_o_fwd_rs1_data = '0;
      wf_o_fwd_rs2_data = '0;
      if (FWD_EN != 0) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            if (slot_valid[STAGES-1-k] && (wf_i_addr_rs1 != '0) &&
                (slot_addr[STAGES-1-k] == wf_i_addr_rs1)) begin
               wf_o_fwd_rs1_hit  = 1'b1;
               wf_o_fwd_rs1_data = slot_data[STAGES-1-k];
            end
            if (slot_valid[STAGES-1-k] && (wf_i_addr_rs2 != '0) &&
                (slot_addr[STAGES-1-k] == wf_i_addr_rs2)) begin
               wf_o_fwd_rs2_hit  = 1'b1;
               wf_o_fwd_rs2_data = slot_data[STAGES-1-k];
            end
         end
      end
   end

   // Committed-write counter, wraps naturally at 32 bits.
   always_ff @(posedge wf_clk or negedge wf_rst) begin
      if (!wf_rst) begin
         retire_cnt <= '0;
      end else if (wf_o_we) begin
         retire_cnt <= retire_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_wb_forward_pipe.sv
// Self-checking bench for wb_forward_pipe (STAGES=2): directed vector table,
// hand-written stall/flush/wrap/reset sequences, and a randomized run against
// a queue-based reference model.
module tb_wb_forward_pipe;

   localparam int S = 2;

   logic        wf_clk = 1'b0;
   logic        wf_rst = 1'b1;
   logic        wf_i_valid = 1'b0, wf_i_we_reg = 1'b0;
   logic [4:0]  wf_i_addr_rd = '0;
   logic [31:0] wf_i_data_rd = '0;
   logic        wf_i_stall = 1'b0, wf_i_flush = 1'b0;
   logic [4:0]  wf_i_addr_rs1 = '0, wf_i_addr_rs2 = '0;
   logic        wf_o_fwd_rs1_hit, wf_o_fwd_rs2_hit;
   logic [31:0] wf_o_fwd_rs1_data, wf_o_fwd_rs2_data;
   logic        wf_o_we;
   logic [4:0]  wf_o_addr_rd;
   logic [31:0] wf_o_data_rd;
   logic        wf_o_busy;
   logic [31:0] wf_o_retire_cnt;

   int checks = 0;
   int errors = 0;

   wb_forward_pipe #(.DWIDTH(32), .AWIDTH(5), .STAGES(S), .FWD_EN(1)) dut (
      .wf_clk(wf_clk), .wf_rst(wf_rst),
      .wf_i_valid(wf_i_valid), .wf_i_we_reg(wf_i_we_reg),
      .wf_i_addr_rd(wf_i_addr_rd), .wf_i_data_rd(wf_i_data_rd),
      .wf_i_stall(wf_i_stall), .wf_i_flush(wf_i_flush),
      .wf_i_addr_rs1(wf_i_addr_rs1), .wf_i_addr_rs2(wf_i_addr_rs2),
      .wf_o_fwd_rs1_hit(wf_o_fwd_rs1_hit), .wf_o_fwd_rs2_hit(wf_o_fwd_rs2_hit),
      .wf_o_fwd_rs1_data(wf_o_fwd_rs1_data), .wf_o_fwd_rs2_data(wf_o_fwd_rs2_data),
      .wf_o_we(wf_o_we), .wf_o_addr_rd(wf_o_addr_rd), .wf_o_data_rd(wf_o_data_rd),
      .wf_o_busy(wf_o_busy), .wf_o_retire_cnt(wf_o_retire_cnt)
   );

   always #5 wf_clk = ~wf_clk;

   initial begin
      #1ms;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic        v, we;
      logic [4:0]  rd;
      logic [31:0] d;
      logic [4:0]  rs1, rs2;
      logic        xwe;
      logic [4:0]  xaddr;
      logic [31:0] xdata;
      logic        xh1;
      logic [31:0] xf1;
      logic        xh2;
      logic [31:0] xf2;
      logic        xbusy;
      logic [31:0] xcnt;
   } vec_t;

   typedef struct {
      logic        v;
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_outputs(input string tag, input logic xwe, input logic [4:0] xaddr,
                                input logic [31:0] xdata, input logic xh1, input logic [31:0] xf1,
                                input logic xh2, input logic [31:0] xf2, input logic xbusy,
                                input logic [31:0] xcnt);
      chk({tag, ".we"}, 32'(wf_o_we), 32'(xwe));
      if (xwe) begin
         chk({tag, ".addr"}, 32'(wf_o_addr_rd), 32'(xaddr));
         chk({tag, ".data"}, wf_o_data_rd, xdata);
      end
      chk({tag, ".hit1"}, 32'(wf_o_fwd_rs1_hit), 32'(xh1));
      chk({tag, ".fwd1"}, wf_o_fwd_rs1_data, xf1);
      chk({tag, ".hit2"}, 32'(wf_o_fwd_rs2_hit), 32'(xh2));
      chk({tag, ".fwd2"}, wf_o_fwd_rs2_data, xf2);
      chk({tag, ".busy"}, 32'(wf_o_busy), 32'(xbusy));
      chk({tag, ".cnt"}, wf_o_retire_cnt, xcnt);
   endtask

   task automatic drive(input logic v, input logic we, input logic [4:0] rd, input logic [31:0] d,
                        input logic st, input logic fl, input logic [4:0] r1, input logic [4:0] r2);
      wf_i_valid = v; wf_i_we_reg = we; wf_i_addr_rd = rd; wf_i_data_rd = d;
      wf_i_stall = st; wf_i_flush = fl; wf_i_addr_rs1 = r1; wf_i_addr_rs2 = r2;
   endtask

   task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
      drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, r1, r2);
   endtask

   task automatic settle();
      #4;
   endtask

   task automatic tick();
      @(posedge wf_clk);
      #1;
   endtask

   // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
   task automatic do_reset(input string tag);
      idle(5'd0, 5'd0);
      wf_rst = 1'b0;
      #2;
      check_outputs(tag, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      chk({tag, ".addr0"}, 32'(wf_o_addr_rd), 32'h0);
      chk({tag, ".data0"}, wf_o_data_rd, 32'h0);
      tick();
      wf_rst = 1'b1;
   endtask

   // Reference model: queue indexed by age (0 = youngest).
   ent_t q[$];

   function automatic logic [32:0] mfwd(input logic [4:0] rs);
      for (int i = 0; i < S; i++) begin
         if (rs != 5'd0 && q[i].v && q[i].a == rs) return {1'b1, q[i].d};
      end
      return 33'h0;
   endfunction

   vec_t tbl[12];

   initial begin
      tbl[0]  = '{1'b1,1'b1,5'd5,32'hDEADBEEF, 5'd5,5'd0, 1'b0,5'd0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0,32'd0};
      tbl[1]  = '{1'b0,1'b0,5'd0,32'h0,        5'd5,5'd5, 1'b0,5'd0,32'h0,        1'b1,32'hDEADBEEF, 1'b1,32'hDEADBEEF, 1'b1,32'd0};
      tbl[2]  = '{1'b0,1'b0,5'd0,32'h0,        5'd5,5'd0, 1'b1,5'd5,32'hDEADBEEF, 1'b1,32'hDEADBEEF, 1'b0,32'h0,        1'b1,32'd0};
      tbl[3]  = '{1'b1,1'b1,5'd0,32'h55,       5'd0,5'd0, 1'b0,5'd0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0,32'd1};
      tbl[4]  = '{1'b0,1'b0,5'd0,32'h0,        5'd0,5'd0, 1'b0,5'd0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0,32'd1};
      tbl[5]  = '{1'b1,1'b1,5'd7,32'h11,       5'd7,5'd0, 1'b0,5'd0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0,32'd1};
      tbl[6]  = '{1'b1,1'b1,5'd7,32'h22,       5'd7,5'd3, 1'b0,5'd0,32'h0,        1'b1,32'h11,       1'b0,32'h0,        1'b1,32'd1};
      tbl[7]  = '{1'b0,1'b0,5'd0,32'h0,        5'd7,5'd7, 1'b1,5'd7,32'h11,       1'b1,32'h22,       1'b1,32'h22,       1'b1,32'd1};
      tbl[8]  = '{1'b0,1'b0,5'd0,32'h0,        5'd7,5'd0, 1'b1,5'd7,32'h22,       1'b1,32'h22,       1'b0,32'h0,        1'b1,32'd2};
      tbl[9]  = '{1'b1,1'b0,5'd9,32'h99,       5'd9,5'd0, 1'b0,5'd0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0,32'd3};
      tbl[10] = '{1'b0,1'b1,5'd9,32'h99,       5'd9,5'd0, 1'b0,5'd0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0,32'd3};
      tbl[11] = '{1'b0,1'b0,5'd0,32'h0,        5'd9,5'd0, 1'b0,5'd0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0,32'd3};

      #1;
      do_reset("reset0");

      // Directed vectors: latency, x0 writes, back-to-back same rd, we_reg/valid gating.
      for (int i = 0; i < 12; i++) begin
         drive(tbl[i].v, tbl[i].we, tbl[i].rd, tbl[i].d, 1'b0, 1'b0, tbl[i].rs1, tbl[i].rs2);
         settle();
         check_outputs($sformatf("vec%0d", i), tbl[i].xwe, tbl[i].xaddr, tbl[i].xdata,
                       tbl[i].xh1, tbl[i].xf1, tbl[i].xh2, tbl[i].xf2, tbl[i].xbusy, tbl[i].xcnt);
         tick();
      end

      // Stall with full slots for 3 cycles, then ordered drain.
      do_reset("reset_stall");
      drive(1'b1, 1'b1, 5'd1, 32'hA1, 1'b0, 1'b0, 5'd0, 5'd0); tick();
      drive(1'b1, 1'b1, 5'd2, 32'hB2, 1'b0, 1'b0, 5'd0, 5'd0); tick();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 5'd3, 32'hC3, 1'b1, 1'b0, 5'd1, 5'd2);
         settle();
         check_outputs($sformatf("stall%0d", i), 1'b0, 5'd0, 32'h0, 1'b1, 32'hA1, 1'b1, 32'hB2, 1'b1, 32'd0);
         tick();
      end
      idle(5'd0, 5'd0); settle();
      check_outputs("drain0", 1'b1, 5'd1, 32'hA1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'd0);
      tick(); settle();
      check_outputs("drain1", 1'b1, 5'd2, 32'hB2, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'd1);
      tick(); settle();
      check_outputs("drain2", 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'd2);
      tick();

      // Flush under stall: oldest commits, younger and input dropped.
      do_reset("reset_flush");
      drive(1'b1, 1'b1, 5'd1, 32'hA1, 1'b0, 1'b0, 5'd0, 5'd0); tick();
      drive(1'b1, 1'b1, 5'd2, 32'hB2, 1'b0, 1'b0, 5'd0, 5'd0); tick();
      drive(1'b1, 1'b1, 5'd3, 32'hD4, 1'b1, 1'b1, 5'd0, 5'd0); settle();
      check_outputs("flush", 1'b1, 5'd1, 32'hA1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'd0);
      tick();
      idle(5'd3, 5'd2); settle();
      check_outputs("postflush", 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'd1);
      tick(); settle();
      check_outputs("postflush2", 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'd1);
      tick();

      // Counter wrap: preload all-ones just before a commit edge.
      do_reset("reset_wrap");
      drive(1'b1, 1'b1, 5'd4, 32'h44, 1'b0, 1'b0, 5'd0, 5'd0); tick();
      idle(5'd0, 5'd0); tick();
      settle();
      force dut.retire_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.retire_cnt;
      #1;
      chk("preload.cnt", wf_o_retire_cnt, 32'hFFFF_FFFF);
      chk("preload.we", 32'(wf_o_we), 32'd1);
      tick();
      drive(1'b1, 1'b1, 5'd8, 32'h88, 1'b0, 1'b0, 5'd0, 5'd0); settle();
      chk("wrap.cnt", wf_o_retire_cnt, 32'h0);
      tick();
      drive(1'b1, 1'b1, 5'd9, 32'h99, 1'b0, 1'b0, 5'd0, 5'd0); tick();
      idle(5'd9, 5'd0); settle();
      check_outputs("prereset0", 1'b1, 5'd8, 32'h88, 1'b1, 32'h99, 1'b0, 32'h0, 1'b1, 32'd0);
      tick(); settle();
      check_outputs("prereset1", 1'b1, 5'd9, 32'h99, 1'b1, 32'h99, 1'b0, 32'h0, 1'b1, 32'd1);

      // Mid-stream asynchronous reset: immediate clear, nothing written afterwards.
      wf_rst = 1'b0;
      #1;
      check_outputs("midrst", 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'd0);
      chk("midrst.addr0", 32'(wf_o_addr_rd), 32'h0);
      chk("midrst.data0", wf_o_data_rd, 32'h0);
      tick();
      wf_rst = 1'b1;
      drive(1'b1, 1'b1, 5'd6, 32'h66, 1'b0, 1'b0, 5'd0, 5'd0); settle();
      check_outputs("rel0", 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'd0);
      tick();
      idle(5'd6, 5'd0); settle();
      check_outputs("rel1", 1'b0, 5'd0, 32'h0, 1'b1, 32'h66, 1'b0, 32'h0, 1'b1, 32'd0);
      tick(); settle();
      check_outputs("rel2", 1'b1, 5'd6, 32'h66, 1'b1, 32'h66, 1'b0, 32'h0, 1'b1, 32'd0);
      tick(); settle();
      check_outputs("rel3", 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'd1);
      tick();

      // Randomized run against the reference model.
      do_reset("reset_rand");
      q.delete();
      for (int i = 0; i < S; i++) q.push_back('{1'b0, 5'd0, 32'h0});
      begin
         logic [31:0] mcnt;
         logic        v, we, st, fl, xwe;
         logic [4:0]  rd, r1, r2;
         logic [31:0] d;
         logic [32:0] f1, f2;
         mcnt = 32'd0;
         for (int n = 0; n < 600; n++) begin
            v  = 1'($urandom_range(0, 1));
            we = ($urandom_range(0, 3) != 0);
            rd = 5'($urandom_range(0, 7));
            d  = $urandom;
            st = ($urandom_range(0, 4) == 0);
            fl = ($urandom_range(0, 9) == 0);
            r1 = 5'($urandom_range(0, 7));
            r2 = 5'($urandom_range(0, 7));
            drive(v, we, rd, d, st, fl, r1, r2);
            settle();
            xwe = q[S-1].v && (!st || fl);
            f1  = mfwd(r1);
            f2  = mfwd(r2);
            check_outputs($sformatf("rnd%0d", n), xwe, q[S-1].a, q[S-1].d,
                          f1[32], f1[31:0], f2[32], f2[31:0],
                          q[0].v | q[S-1].v, mcnt);
            if (fl) begin
               foreach (q[k]) q[k].v = 1'b0;
            end else if (!st) begin
               q.push_front('{v && we && (rd != 5'd0), rd, d});
               void'(q.pop_back());
            end
            if (xwe) mcnt = mcnt + 32'd1;
            tick();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_forward_pipe.md
WB_FORWARD_PIPE -- requirements
Module: wb_forward_pipe

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, data width.
REQ-002 SHALL have parameter AWIDTH, default 5, register address width.
REQ-003 SHALL have parameter STAGES, default 2, writeback pipeline depth, legal range 1..4.
REQ-004 SHALL have parameter FWD_EN, default 1, forwarding enable; 0 ties both hit outputs to 0.
REQ-005 SHALL have port wf_clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port wf_rst  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port wf_i_valid  in  1  EX result valid this cycle.
REQ-008 SHALL have port wf_i_we_reg  in  1  EX result targets register file.
REQ-009 SHALL have port wf_i_addr_rd  in  AWIDTH  destination register.
REQ-010 SHALL have port wf_i_data_rd  in  DWIDTH  result data.
REQ-011 SHALL have port wf_i_stall  in  1  hold all slots.
REQ-012 SHALL have port wf_i_flush  in  1  kill non-committing entries.
REQ-013 SHALL have ports wf_i_addr_rs1, wf_i_addr_rs2  in  AWIDTH  forwarding lookup addresses.
REQ-014 SHALL have ports wf_o_fwd_rs1_hit, wf_o_fwd_rs2_hit  out  1  lookup matched an in-flight slot.
REQ-015 SHALL have ports wf_o_fwd_rs1_data, wf_o_fwd_rs2_data  out  DWIDTH  forwarded value.
REQ-016 SHALL have ports wf_o_we (1), wf_o_addr_rd (AWIDTH), wf_o_data_rd (DWIDTH)  out  register-file write port.
REQ-017 SHALL have port wf_o_busy  out  1  any slot valid.
REQ-018 SHALL have port wf_o_retire_cnt  out  32  committed-write counter.

Function
REQ-019 SHALL hold STAGES slots {valid, addr, data}; slot 0 youngest, slot STAGES-1 committing.
REQ-020 SHALL, on an edge with stall=0 and flush=0, load slot 0 with valid = wf_i_valid & wf_i_we_reg & (wf_i_addr_rd != 0) and shift slot k-1 into slot k.
REQ-021 SHALL drive wf_o_we = slot[STAGES-1].valid & ~wf_i_stall, with wf_o_addr_rd/wf_o_data_rd taken from slot[STAGES-1] combinationally.
REQ-022 SHALL give a latency of exactly STAGES cycles from input presentation (stall-free) to wf_o_we high.
REQ-023 SHALL, while stall=1 and flush=0, hold every slot unchanged, drop the input, and keep wf_o_we=0.
REQ-024 SHALL, on flush=1, clear valid of the input and of slots 0..STAGES-2, while slot[STAGES-1] commits that cycle and then clears; flush overrides stall.
REQ-025 SHALL, with STAGES=1, apply REQ-024 as: the single slot commits, the input is dropped.
REQ-026 SHALL drive the combinational forward hit on a match of the lookup address against a valid slot, lookup address != 0; the youngest matching slot supplies the data.
REQ-027 SHALL drive forward data = 0 when hit=0.
REQ-028 SHALL commit entries whose rd matches across several slots in age order, oldest first.
REQ-029 SHALL increment wf_o_retire_cnt by 1 on each cycle with wf_o_we=1, wrapping 0xFFFFFFFF -> 0.
REQ-030 SHALL drive wf_o_busy = OR of all slot valids.

Reset
REQ-031 SHALL, on wf_rst=0, immediately clear all slot valid/addr/data and wf_o_retire_cnt; all outputs read 0.
REQ-032 SHALL discard in-flight entries on a reset asserted mid-operation, with no write after release.
REQ-033 SHALL accept input on the first rising edge after wf_rst returns to 1.

Verification
REQ-034 SHALL be verified, STAGES=2: valid, we_reg=1, rd=5, data=0xDEADBEEF at cycle 0 -> wf_o_we=1, addr 5, data 0xDEADBEEF at cycle 2; retire_cnt=1.
REQ-035 SHALL be verified: rd=0 with valid=1 -> no write, no forward hit, busy stays 0.
REQ-036 SHALL be verified: rd=7 data 0x11 then rd=7 data 0x22 back-to-back, rs1=7 -> hit=1 data 0x22; writes 0x11 then 0x22 on consecutive cycles.
REQ-037 SHALL be verified: slots full, stall=1 for 3 cycles -> wf_o_we=0, slots unchanged; release -> writes resume in order.
REQ-038 SHALL be verified: flush with stall=1 and both slots valid -> the oldest entry commits (wf_o_we=1) and the younger is dropped; busy=0 next cycle.
REQ-039 SHALL be verified: preload retire_cnt to 0xFFFFFFFF via 2^32-1 commits (forced) plus one commit -> 0; mid-stream wf_rst=0 -> all outputs 0 asynchronously.
